tag_pushbutton_debouncer: RTL and testbench

Input conditioner for the board push-buttons: synchronizes the raw active-low KEY pins into the `clk` domain, debounces each button independently, and presents a clean active-high level vector. The level vector drives the `in_port` of the push-button PIO slave, whose interrupt logic is level-sensitive and requires glitch-free inputs. One-cycle press and release pulses are also produced for local consumers.

---
 rtl/tag_pushbutton_debouncer.sv | 64 ++++++
 tb/tb_tag_pushbutton_debouncer.sv | 106 ++++++++++
 2 files changed

// File: rtl/tag_pushbutton_debouncer.sv
// Push-button input conditioner: two-flop synchronizer, per-bit debounce
// counter, active-high debounced level plus one-cycle press/release pulses.
module tag_pushbutton_debouncer #(
    parameter int WIDTH           = 4,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] key_n,
    output logic [WIDTH-1:0] btn_level,
    output logic [WIDTH-1:0] btn_press,
    output logic [WIDTH-1:0] btn_release
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0] r_s1;
    logic [WIDTH-1:0] r_s2;
    logic [WIDTH-1:0] r_stable;
    logic [WIDTH-1:0] r_press;
    logic [WIDTH-1:0] r_release;
    logic [CNT_W-1:0] r_cnt [WIDTH];
    logic [WIDTH-1:0] w_raw;

    // Synchronized pins are active-low; invert once so everything downstream is 1 = pressed.
    assign w_raw = ~r_s2;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_s1      <= '1;
            r_s2      <= '1;
            r_stable  <= '0;
            r_press   <= '0;
            r_release <= '0;
            for (int i = 0; i < WIDTH; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            r_s1 <= key_n;
            r_s2 <= r_s1;
            for (int i = 0; i < WIDTH; i++) begin
                r_press[i]   <= 1'b0;
                r_release[i] <= 1'b0;
                if (w_raw[i] == r_stable[i]) begin
                    r_cnt[i] <= '0;
                end else if (r_cnt[i] == CNT_MAX) begin
                    // Input differed for DEBOUNCE_CYCLES consecutive cycles: accept it.
                    r_stable[i]  <= w_raw[i];
                    r_cnt[i]     <= '0;
                    r_press[i]   <= w_raw[i];
                    r_release[i] <= ~w_raw[i];
                end else begin
                    r_cnt[i] <= r_cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    assign btn_level   = r_stable;
    assign btn_press   = r_press;
    assign btn_release = r_release;

endmodule

// File: tb/tb_tag_pushbutton_debouncer.sv
// Directed bench for tag_pushbutton_debouncer with DEBOUNCE_CYCLES=4, WIDTH=4;
// every cycle of interest compares {level, press, release} against hand-derived values.
module tb_tag_pushbutton_debouncer;

    logic       clk;
    logic       reset;
    logic [3:0] key_n;
    logic [3:0] btn_level;
    logic [3:0] btn_press;
    logic [3:0] btn_release;

    int n_cmp;
    int n_mis;

    tag_pushbutton_debouncer #(
        .WIDTH           (4),
        .DEBOUNCE_CYCLES (4)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .key_n       (key_n),
        .btn_level   (btn_level),
        .btn_press   (btn_press),
        .btn_release (btn_release)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge, then compare outputs 1 time unit later.
    task automatic tick_check(input string tag, input logic [3:0] lv,
                              input logic [3:0] pr, input logic [3:0] rl);
        @(posedge clk);
        #1;
        n_cmp++;
        assert ({btn_level, btn_press, btn_release} === {lv, pr, rl})
        else begin
            n_mis++;
            $error("FAIL %s: observed lvl/prs/rel=%h/%h/%h expected %h/%h/%h",
                   tag, btn_level, btn_press, btn_release, lv, pr, rl);
        end
    endtask

    // Key already driven before the next edge: 5 quiet edges, then accept, then settle.
    task automatic expect_accept(input string tag, input logic [3:0] old_lv,
                                 input logic [3:0] new_lv, input logic [3:0] pr,
                                 input logic [3:0] rl);
        for (int k = 0; k < 5; k++) tick_check({tag, "_wait"}, old_lv, 4'h0, 4'h0);
        tick_check({tag, "_edge"}, new_lv, pr, rl);
        tick_check({tag, "_after"}, new_lv, 4'h0, 4'h0);
        tick_check({tag, "_hold"}, new_lv, 4'h0, 4'h0);
    endtask

    initial begin
        n_cmp = 0;
        n_mis = 0;
        reset = 1'b1;
        key_n = 4'hF;

        // Reset for two edges, then idle with all keys released.
        tick_check("reset_0", 4'h0, 4'h0, 4'h0);
        tick_check("reset_1", 4'h0, 4'h0, 4'h0);
        reset = 1'b0;
        for (int k = 0; k < 20; k++) tick_check("idle", 4'h0, 4'h0, 4'h0);

        // Clean press and release of bit 0.
        key_n = 4'hE;
        expect_accept("press0", 4'h0, 4'h1, 4'h1, 4'h0);
        key_n = 4'hF;
        expect_accept("release0", 4'h1, 4'h0, 4'h0, 4'h1);

        // Bounce on bit 1: 3-cycle low windows never reach acceptance.
        key_n = 4'hD;
        for (int k = 0; k < 3; k++) tick_check("bounce_lo1", 4'h0, 4'h0, 4'h0);
        key_n = 4'hF;
        for (int k = 0; k < 3; k++) tick_check("bounce_hi1", 4'h0, 4'h0, 4'h0);
        key_n = 4'hD;
        for (int k = 0; k < 3; k++) tick_check("bounce_lo2", 4'h0, 4'h0, 4'h0);
        key_n = 4'hF;
        for (int k = 0; k < 3; k++) tick_check("bounce_hi2", 4'h0, 4'h0, 4'h0);
        key_n = 4'hD;
        expect_accept("bounce_hold", 4'h0, 4'h2, 4'h2, 4'h0);
        key_n = 4'hF;
        expect_accept("release1", 4'h2, 4'h0, 4'h0, 4'h2);

        // Bits 1 and 3 pressed on the same edge.
        key_n = 4'h5;
        expect_accept("simul_press", 4'h0, 4'hA, 4'hA, 4'h0);
        key_n = 4'hF;
        expect_accept("simul_release", 4'hA, 4'h0, 4'h0, 4'hA);

        // Bit 2 pressed, reset hits mid-count, key stays held through reset.
        key_n = 4'hB;
        for (int k = 0; k < 3; k++) tick_check("pre_reset", 4'h0, 4'h0, 4'h0);
        reset = 1'b1;
        tick_check("mid_reset_0", 4'h0, 4'h0, 4'h0);
        tick_check("mid_reset_1", 4'h0, 4'h0, 4'h0);
        reset = 1'b0;
        expect_accept("post_reset", 4'h0, 4'h4, 4'h4, 4'h0);
        for (int k = 0; k < 4; k++) tick_check("post_reset_hold", 4'h4, 4'h0, 4'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
